// File: rtl/cam_pkg.sv
// Shared types and header formatting for the dual camera line arbiter.
package cam_pkg;

    localparam int unsigned LINE_CNT_W    = 12;
    localparam int unsigned HDR_SEL_BIT   = 7;
    localparam int unsigned HDR_FIRST_BIT = 6;
    localparam int unsigned HDR_LINE_HI_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_HDR0,
        ST_HDR1,
        ST_HDR2,
        ST_HDR3,
        ST_PIX,
        ST_NEXT
    } arb_state_t;

    // Header byte idx of a line: sync, flags/line-high, line-low, check byte.
    function automatic logic [7:0] hdr_byte(
        input logic [1:0]            idx,
        input logic                  sel,
        input logic [LINE_CNT_W-1:0] line,
        input logic [7:0]            sync_byte,
        input logic [7:0]            pix_lo
    );
        logic [7:0] b;
        b = '0;
        case (idx)
            2'd0: b = sync_byte;
            2'd1: begin
                b[HDR_SEL_BIT]          = sel;
                b[HDR_FIRST_BIT]        = (line == '0);
                b[HDR_LINE_HI_W-1:0]    = line[LINE_CNT_W-1 -: HDR_LINE_HI_W];
            end
            2'd2: b = line[7:0];
            default: b = pix_lo ^ {7'b0, sel};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/cam_sof_aligner.sv
// Per-camera start-of-frame alignment: drops bytes until SOF, then holds SOF.
module cam_sof_aligner (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic valid,
    input  logic sof,
    output logic ready,
    output logic sync
);

    // Sync flag is set by a valid SOF while aligning and cleared outside ALIGN.
    always_ff @(posedge clk) begin
        if (rst || !active) begin
            sync <= 1'b0;
        end else if (valid && sof) begin
            sync <= 1'b1;
        end
    end

    // Consume junk bytes; never consume the SOF byte so it starts the first line.
    always_comb begin
        ready = active && !sync && !(valid && sof);
    end

endmodule

// File: rtl/dual_cam_line_arbiter.sv
// Interleaves whole lines of two camera streams onto one byte stream,
// prefixing each line with a 4-byte header.
import cam_pkg::*;

module dual_cam_line_arbiter #(
    parameter int unsigned LINE_PIXELS = 640,
    parameter int unsigned FRAME_LINES = 480,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stream_en,
    output logic       start_stream,
    input  logic [7:0] cam0_pixel,
    input  logic       cam0_valid,
    input  logic       cam0_sof,
    output logic       cam0_ready,
    input  logic [7:0] cam1_pixel,
    input  logic       cam1_valid,
    input  logic       cam1_sof,
    output logic       cam1_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy
);

    localparam logic [LINE_CNT_W-1:0] LAST_PIX  = LINE_CNT_W'(LINE_PIXELS - 1);
    localparam logic [LINE_CNT_W-1:0] LAST_LINE = LINE_CNT_W'(FRAME_LINES - 1);
    localparam logic [7:0]            PIX_LO    = 8'(LINE_PIXELS);

    arb_state_t            state;
    logic                  sel;
    logic [LINE_CNT_W-1:0] line_cnt;
    logic [LINE_CNT_W-1:0] pix_cnt;
    logic                  resync;

    logic                  aligning;
    logic                  sync0;
    logic                  sync1;
    logic                  al_ready0;
    logic                  al_ready1;

    logic [7:0]            sel_pixel;
    logic                  sel_valid;
    logic                  sel_sof;
    logic                  xfer;
    logic                  sof_mid;

    assign aligning = (state == ST_ALIGN);

    cam_sof_aligner u_align0 (
        .clk    (clk),
        .rst    (rst),
        .active (aligning),
        .valid  (cam0_valid),
        .sof    (cam0_sof),
        .ready  (al_ready0),
        .sync   (sync0)
    );

    cam_sof_aligner u_align1 (
        .clk    (clk),
        .rst    (rst),
        .active (aligning),
        .valid  (cam1_valid),
        .sof    (cam1_sof),
        .ready  (al_ready1),
        .sync   (sync1)
    );

    // Selected-camera view used by the pixel pass-through.
    always_comb begin
        sel_pixel = sel ? cam1_pixel : cam0_pixel;
        sel_valid = sel ? cam1_valid : cam0_valid;
        sel_sof   = sel ? cam1_sof   : cam0_sof;
        xfer      = out_valid && out_ready;
        sof_mid   = sel_sof && ((pix_cnt != '0) || (line_cnt != '0));
    end

    // Output mux: headers from state, pixels passed straight through in PIX.
    always_comb begin
        out_data     = '0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        cam0_ready   = 1'b0;
        cam1_ready   = 1'b0;
        start_stream = (state != ST_IDLE);
        busy         = (state != ST_IDLE);
        case (state)
            ST_ALIGN: begin
                cam0_ready = al_ready0;
                cam1_ready = al_ready1;
            end
            ST_HDR0: begin
                out_valid = 1'b1;
                out_data  = hdr_byte(2'd0, sel, line_cnt, SYNC_BYTE, PIX_LO);
            end
            ST_HDR1: begin
                out_valid = 1'b1;
                out_data  = hdr_byte(2'd1, sel, line_cnt, SYNC_BYTE, PIX_LO);
            end
            ST_HDR2: begin
                out_valid = 1'b1;
                out_data  = hdr_byte(2'd2, sel, line_cnt, SYNC_BYTE, PIX_LO);
            end
            ST_HDR3: begin
                out_valid = 1'b1;
                out_data  = hdr_byte(2'd3, sel, line_cnt, SYNC_BYTE, PIX_LO);
            end
            ST_PIX: begin
                out_data  = sel_pixel;
                out_valid = sel_valid;
                out_last  = sel_valid && sel && (line_cnt == LAST_LINE) && (pix_cnt == LAST_PIX);
                if (sel) begin
                    cam1_ready = out_ready;
                end else begin
                    cam0_ready = out_ready;
                end
            end
            default: ;
        endcase
    end

    // Arbiter FSM with line/pixel counters and camera select.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            sel      <= 1'b0;
            line_cnt <= '0;
            pix_cnt  <= '0;
            resync   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (stream_en) begin
                        state    <= ST_ALIGN;
                        sel      <= 1'b0;
                        line_cnt <= '0;
                        pix_cnt  <= '0;
                        resync   <= 1'b0;
                    end
                end
                ST_ALIGN: begin
                    if (!stream_en) begin
                        state <= ST_IDLE;
                    end else if (sync0 && sync1) begin
                        state   <= ST_HDR0;
                        sel     <= 1'b0;
                        pix_cnt <= '0;
                    end
                end
                ST_HDR0: if (out_ready) state <= ST_HDR1;
                ST_HDR1: if (out_ready) state <= ST_HDR2;
                ST_HDR2: if (out_ready) state <= ST_HDR3;
                ST_HDR3: begin
                    if (out_ready) begin
                        state   <= ST_PIX;
                        pix_cnt <= '0;
                    end
                end
                ST_PIX: begin
                    if (xfer) begin
                        pix_cnt <= pix_cnt + 1'b1;
                        // A stray SOF on the final byte still forces re-alignment.
                        if (pix_cnt == LAST_PIX) begin
                            if (resync || sof_mid) begin
                                state    <= ST_ALIGN;
                                sel      <= 1'b0;
                                line_cnt <= '0;
                                resync   <= 1'b0;
                            end else begin
                                state <= ST_NEXT;
                            end
                        end else if (sof_mid) begin
                            resync <= 1'b1;
                        end
                    end
                end
                ST_NEXT: begin
                    if (!stream_en) begin
                        state    <= ST_IDLE;
                        sel      <= 1'b0;
                        line_cnt <= '0;
                    end else if (!sel) begin
                        sel   <= 1'b1;
                        state <= ST_HDR0;
                    end else if (line_cnt != LAST_LINE) begin
                        sel      <= 1'b0;
                        line_cnt <= line_cnt + 1'b1;
                        state    <= ST_HDR0;
                    end else begin
                        sel      <= 1'b0;
                        line_cnt <= '0;
                        state    <= ST_ALIGN;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
